// File: rtl/penta_pkg.sv
// Shared definitions for the penta (base-5) serial adder: digit geometry,
// controller states and the digit legality check.
package penta_pkg;

    localparam int PENTA_BASE = 5;
    localparam int DIG_W      = 3;
    localparam int DIG_MAX    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic penta_digit_valid(input logic [DIG_W-1:0] digit);
        return digit <= DIG_MAX[DIG_W-1:0];
    endfunction

endpackage

// File: rtl/penta_full_adder.sv
// Single base-5 digit adder with carry in/out.
// Latency: combinational. Backpressure: none, pure function of inputs.
// Assumes legal digits; 4+4+1 = 9 keeps the carry out at most 1.
module penta_full_adder
    import penta_pkg::*;
(
    input  logic [DIG_W-1:0] a_d,
    input  logic [DIG_W-1:0] b_d,
    input  logic             cin,
    output logic [DIG_W-1:0] s_d,
    output logic             cout
);

    localparam logic [DIG_W:0] BASE_W = PENTA_BASE[DIG_W:0];

    logic [DIG_W:0] raw;
    logic [DIG_W:0] wrapped;

    always_comb begin
        raw     = {1'b0, a_d} + {1'b0, b_d} + {{DIG_W{1'b0}}, cin};
        wrapped = raw - BASE_W;
        if (raw >= BASE_W) begin
            s_d  = wrapped[DIG_W-1:0];
            cout = 1'b1;
        end else begin
            s_d  = raw[DIG_W-1:0];
            cout = 1'b0;
        end
    end

endmodule

// File: rtl/penta_serial_adder_ctrl.sv
// Adds two NDIG-digit base-5 numbers LSD first through one shared digit adder.
// Latency: valid request done NDIG edges after the start edge, illegal request 1 edge after.
// Backpressure: start is ignored while busy; no queueing, results held until next completion.
module penta_serial_adder_ctrl
    import penta_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIG_W*NDIG-1:0] a,
    input  logic [DIG_W*NDIG-1:0] b,
    output logic                  busy,
    output logic                  done,
    output logic [DIG_W*NDIG-1:0] sum,
    output logic                  cout,
    output logic                  err
);

    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                  state;
    state_t                  state_nxt;
    logic [DIG_W*NDIG-1:0]   opa;
    logic [DIG_W*NDIG-1:0]   opb;
    logic [DIG_W*NDIG-1:0]   wsum;
    logic [DIG_W*NDIG-1:0]   wsum_nxt;
    logic [IW-1:0]           idx;
    logic                    carry;
    logic                    bad;
    logic                    in_ok;
    logic                    last;
    logic [DIG_W-1:0]        a_d;
    logic [DIG_W-1:0]        b_d;
    logic [DIG_W-1:0]        s_d;
    logic                    fa_cout;

    always_comb begin
        in_ok = 1'b1;
        for (int i = 0; i < NDIG; i++) begin
            if (!penta_digit_valid(a[i*DIG_W +: DIG_W]) ||
                !penta_digit_valid(b[i*DIG_W +: DIG_W]))
                in_ok = 1'b0;
        end
    end

    // Digit select and write-back are explicit decodes over idx.
    always_comb begin
        a_d      = '0;
        b_d      = '0;
        wsum_nxt = wsum;
        for (int i = 0; i < NDIG; i++) begin
            if (idx == IW'(i)) begin
                a_d = opa[i*DIG_W +: DIG_W];
                b_d = opb[i*DIG_W +: DIG_W];
                wsum_nxt[i*DIG_W +: DIG_W] = s_d;
            end
        end
    end

    assign last = (idx == IW'(NDIG-1));

    penta_full_adder u_fa (
        .a_d  (a_d),
        .b_d  (b_d),
        .cin  (carry),
        .s_d  (s_d),
        .cout (fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // An illegal request still spends one cycle in ADD so that done lands one
    // edge after the start edge; that cycle only publishes the error result.
    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nxt = ADD;
            end
            ADD: begin
                if (bad || last)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            wsum  <= '0;
            idx   <= '0;
            carry <= 1'b0;
            bad   <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        wsum  <= '0;
                        idx   <= '0;
                        carry <= 1'b0;
                        bad   <= !in_ok;
                    end
                end
                ADD: begin
                    if (bad) begin
                        sum  <= '0;
                        cout <= 1'b0;
                        err  <= 1'b1;
                    end else begin
                        wsum  <= wsum_nxt;
                        carry <= fa_cout;
                        idx   <= idx + IW'(1);
                        if (last) begin
                            sum  <= wsum_nxt;
                            cout <= fa_cout;
                            err  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_penta_serial_adder_ctrl.sv
// Directed bench for penta_serial_adder_ctrl (NDIG=4); expected values hand-computed in base 5.
module tb_penta_serial_adder_ctrl;

    localparam int NDIG = 4;
    localparam int W    = 3*NDIG;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    penta_serial_adder_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .err   (err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] p5(input int d3, input int d2, input int d1, input int d0);
        logic [W-1:0] r;
        r = {3'(d3), 3'(d2), 3'(d1), 3'(d0)};
        return r;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic [W-1:0] es, input logic ec, input logic ee,
                      input int elat, input bit disturb);
        int lat;
        int busyc;
        start = 1'b1;
        a     = ta;
        b     = tb;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a     = 12'($urandom);
        lat   = 0;
        busyc = 0;
        while (!done && lat < 20) begin
            if (busy) busyc++;
            if (disturb && lat < 3) begin
                start = 1'b1;
                a     = 12'($urandom);
                b     = 12'($urandom);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (busy) busyc++;
        chk({tag, "_lat"},   lat,   elat);
        chk({tag, "_busyc"}, busyc, elat + 1);
        chk({tag, "_done"},  done,  1'b1);
        chk({tag, "_sum"},   sum,   es);
        chk({tag, "_cout"},  cout,  ec);
        chk({tag, "_err"},   err,   ee);
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_done_lo"}, done, 1'b0);
        chk({tag, "_idle"},    busy, 1'b0);
        chk({tag, "_hold"},    sum,  es);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum",  sum,  '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_err",  err,  1'b0);

        op("basic",  p5(0,1,2,3), p5(0,3,2,1), p5(0,4,4,4), 1'b0, 1'b0, NDIG, 1'b0);
        op("ripple", p5(4,4,4,4), p5(0,0,0,1), p5(0,0,0,0), 1'b1, 1'b0, NDIG, 1'b0);
        op("maxmax", p5(4,4,4,4), p5(4,4,4,4), p5(4,4,4,3), 1'b1, 1'b0, NDIG, 1'b0);
        op("zeros",  p5(0,0,0,0), p5(0,0,0,0), p5(0,0,0,0), 1'b0, 1'b0, NDIG, 1'b0);
        op("bad_a",  p5(0,0,5,0), p5(0,0,0,1), p5(0,0,0,0), 1'b0, 1'b1, 1, 1'b0);
        op("clr_err", p5(1,2,3,4), p5(0,0,1,0), p5(1,2,4,4), 1'b0, 1'b0, NDIG, 1'b0);
        op("bad_b",  p5(0,0,0,0), p5(7,0,0,0), p5(0,0,0,0), 1'b0, 1'b1, 1, 1'b0);
        op("disturb", p5(0,1,2,3), p5(0,3,2,1), p5(0,4,4,4), 1'b0, 1'b0, NDIG, 1'b1);

        // Reset while idx=2, then a fresh request must complete normally.
        start = 1'b1;
        a     = p5(4,4,4,4);
        b     = p5(4,4,4,4);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_sum",  sum,  '0);
        chk("mrst_cout", cout, 1'b0);
        chk("mrst_err",  err,  1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_nodone", done, 1'b0);

        op("after_rst", p5(2,3,4,1), p5(3,2,1,3), p5(1,1,0,4), 1'b1, 1'b0, NDIG, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
